ahb_sram_slave_if: RTL and testbench

AHB-Lite slave front end for the embedded SRAM store. It accepts pipelined AHB transfers, checks them for legality, and issues one-cycle request pulses to the downstream SRAM control interface (ahbsram_* / sramahb_*). It inserts wait states until that stage acknowledges, and returns read data and the OKAY or ERROR response to the bus.

---
 rtl/ahb_sram_pkg.sv | 25 ++
 rtl/ahb_xfer_check.sv | 25 ++
 rtl/ahb_sram_slave_if.sv | 112 +++++++++++
 tb/tb_ahb_sram_slave_if.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_pkg.sv
// Shared encodings for the AHB-Lite SRAM slave: FSM states and HTRANS/HSIZE/HRESP codes.
// Pure declarations; no timing or flow-control behaviour lives here.
package ahb_sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

endpackage

// File: rtl/ahb_xfer_check.sv
// Legality check of an AHB address phase (size, range, alignment); purely combinational.
// Zero latency, no flow control.
module ahb_xfer_check
  import ahb_sram_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 2048
) (
  input  logic [2:0]  i_size,
  input  logic [19:0] i_addr,
  output logic        o_illegal
);

  logic w_size_bad;
  logic w_range_bad;
  logic w_align_bad;

  always_comb begin
    w_size_bad  = (i_size > HSIZE_WORD);
    w_range_bad = ({12'd0, i_addr} >= MEM_BYTES);
    w_align_bad = ((i_size == HSIZE_HALF) && i_addr[0]) ||
                  ((i_size == HSIZE_WORD) && (i_addr[1:0] != 2'b00));
    o_illegal   = w_size_bad | w_range_bad | w_align_bad;
  end

endmodule

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave front end issuing one-cycle requests to the SRAM control stage.
// Two wait states per legal transfer plus one per BUSY cycle; 2-cycle ERROR response.
module ahb_sram_slave_if
  import ahb_sram_pkg::*;
#(
  parameter int unsigned AHB_DWIDTH = 32,
  parameter int unsigned MEM_BYTES  = 2048
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  HSEL,
  input  logic                  HREADYIN,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [19:0]           HADDR,
  input  logic [AHB_DWIDTH-1:0] HWDATA,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  output logic [AHB_DWIDTH-1:0] HRDATA,
  output logic                  ahbsram_req,
  output logic                  ahbsram_write,
  output logic [2:0]            ahbsram_size,
  output logic [19:0]           ahbsram_addr,
  output logic [AHB_DWIDTH-1:0] ahbsram_wdata,
  input  logic                  sramahb_ack,
  input  logic [AHB_DWIDTH-1:0] sramahb_rdata,
  input  logic                  BUSY
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [19:0] r_addr;
  logic [2:0]  r_size;
  logic        r_write;
  logic        w_valid;
  logic        w_illegal;
  logic        w_capture;
  logic        w_ready;
  logic [1:0]  w_resp;
  logic        w_req;

  assign w_valid = HSEL & HREADYIN & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));

  ahb_xfer_check #(.MEM_BYTES(MEM_BYTES)) u_check (
    .i_size    (HSIZE),
    .i_addr    (HADDR),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_size  <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_addr  <= HADDR;
        r_size  <= HSIZE;
        r_write <= HWRITE;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b1;
    w_resp      = HRESP_OKAY;
    w_req       = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        if (r_state == ST_ERR2) w_resp = HRESP_ERROR;
        w_capture   = w_valid;
        w_state_nxt = !w_valid ? ST_IDLE : (w_illegal ? ST_ERR1 : ST_ISSUE);
      end
      ST_ISSUE: begin
        w_ready = 1'b0;
        if (!BUSY) begin
          w_req       = 1'b1;
          w_state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // The ack arrives registered, so it can drive HREADYOUT directly.
        w_ready = sramahb_ack;
        if (sramahb_ack) begin
          w_capture   = w_valid;
          w_state_nxt = !w_valid ? ST_IDLE : (w_illegal ? ST_ERR1 : ST_ISSUE);
        end
      end
      ST_ERR1: begin
        w_ready     = 1'b0;
        w_resp      = HRESP_ERROR;
        w_state_nxt = ST_ERR2;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign HREADYOUT     = w_ready;
  assign HRESP         = w_resp;
  assign HRDATA        = sramahb_rdata;
  assign ahbsram_req   = w_req;
  assign ahbsram_write = r_write;
  assign ahbsram_size  = r_size;
  assign ahbsram_addr  = r_addr;
  assign ahbsram_wdata = HWDATA;

endmodule

// File: tb/tb_ahb_sram_slave_if.sv
// Directed bench for ahb_sram_slave_if with a small behavioural SRAM stage (ack two cycles after req).
module tb_ahb_sram_slave_if;
  import ahb_sram_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETN = 1'b0;
  logic        HSEL = 1'b0;
  logic        HREADYIN;
  logic [1:0]  HTRANS = HTRANS_IDLE;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'b000;
  logic [19:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic        ahbsram_req;
  logic        ahbsram_write;
  logic [2:0]  ahbsram_size;
  logic [19:0] ahbsram_addr;
  logic [31:0] ahbsram_wdata;
  logic        sramahb_ack = 1'b0;
  logic [31:0] sramahb_rdata = '0;
  logic        BUSY = 1'b0;

  int cmp = 0;
  int bad = 0;
  int nreq = 0;
  int viol = 0;
  logic prev_req = 1'b0;

  assign HREADYIN = HREADYOUT;

  ahb_sram_slave_if #(.AHB_DWIDTH(32), .MEM_BYTES(2048)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HREADYIN(HREADYIN),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HADDR(HADDR),
    .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .ahbsram_req(ahbsram_req), .ahbsram_write(ahbsram_write),
    .ahbsram_size(ahbsram_size), .ahbsram_addr(ahbsram_addr),
    .ahbsram_wdata(ahbsram_wdata), .sramahb_ack(sramahb_ack),
    .sramahb_rdata(sramahb_rdata), .BUSY(BUSY)
  );

  always #5 HCLK = ~HCLK;

  // SRAM stage model: writes on req, read data and ack two cycles later.
  logic [31:0] mem [0:511];
  logic        pend = 1'b0;
  logic        p_write = 1'b0;
  logic [19:0] p_addr = '0;

  function automatic logic [3:0] byte_en(input logic [2:0] sz, input logic [1:0] a);
    case (sz)
      HSIZE_BYTE: byte_en = 4'b0001 << a;
      HSIZE_HALF: byte_en = a[1] ? 4'b1100 : 4'b0011;
      default:    byte_en = 4'b1111;
    endcase
  endfunction

  initial for (int i = 0; i < 512; i++) mem[i] = '0;

  always @(posedge HCLK) begin
    sramahb_ack <= pend;
    if (pend && !p_write) sramahb_rdata <= mem[p_addr[10:2]];
    pend <= ahbsram_req;
    if (ahbsram_req) begin
      p_write <= ahbsram_write;
      p_addr  <= ahbsram_addr;
      if (ahbsram_write)
        for (int b = 0; b < 4; b++)
          if (byte_en(ahbsram_size, ahbsram_addr[1:0])[b])
            mem[ahbsram_addr[10:2]][8*b +: 8] <= ahbsram_wdata[8*b +: 8];
    end
  end

  always @(negedge HCLK) begin
    if (ahbsram_req) nreq++;
    if (ahbsram_req && (BUSY || prev_req)) viol++;
    prev_req = ahbsram_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_phase(input logic wr, input logic [2:0] sz, input logic [19:0] a);
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = wr; HSIZE = sz; HADDR = a;
  endtask

  task automatic idle_bus();
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
  endtask

  // Entered and left at the drive point just after a rising edge.
  task automatic xfer(input string tag, input logic wr, input logic [2:0] sz,
                      input logic [19:0] a, input logic [31:0] wd, input logic [31:0] exp_rd);
    addr_phase(wr, sz, a);
    @(negedge HCLK); chk({tag, "_A_rdy"}, 32'(HREADYOUT), 32'd1);
    next_cycle(); idle_bus(); HWDATA = wd;
    @(negedge HCLK);
    chk({tag, "_A1_req"}, 32'(ahbsram_req), 32'd1);
    chk({tag, "_A1_rdy"}, 32'(HREADYOUT), 32'd0);
    chk({tag, "_A1_addr"}, 32'(ahbsram_addr), 32'(a));
    chk({tag, "_A1_size"}, 32'(ahbsram_size), 32'(sz));
    chk({tag, "_A1_wr"}, 32'(ahbsram_write), 32'(wr));
    next_cycle(); @(negedge HCLK);
    chk({tag, "_A2_rdy"}, 32'(HREADYOUT), 32'd0);
    chk({tag, "_A2_req"}, 32'(ahbsram_req), 32'd0);
    next_cycle(); @(negedge HCLK);
    chk({tag, "_A3_rdy"}, 32'(HREADYOUT), 32'd1);
    chk({tag, "_A3_resp"}, 32'(HRESP), 32'(HRESP_OKAY));
    if (!wr) chk({tag, "_A3_rdata"}, HRDATA, exp_rd);
    next_cycle();
  endtask

  task automatic err_xfer(input string tag, input logic [2:0] sz, input logic [19:0] a);
    int n0;
    n0 = nreq;
    addr_phase(1'b0, sz, a);
    next_cycle(); idle_bus();
    @(negedge HCLK);
    chk({tag, "_err1_rdy"}, 32'(HREADYOUT), 32'd0);
    chk({tag, "_err1_resp"}, 32'(HRESP), 32'(HRESP_ERROR));
    chk({tag, "_err1_req"}, 32'(ahbsram_req), 32'd0);
    next_cycle(); @(negedge HCLK);
    chk({tag, "_err2_rdy"}, 32'(HREADYOUT), 32'd1);
    chk({tag, "_err2_resp"}, 32'(HRESP), 32'(HRESP_ERROR));
    next_cycle(); @(negedge HCLK);
    chk({tag, "_idle_resp"}, 32'(HRESP), 32'(HRESP_OKAY));
    chk({tag, "_nreq"}, 32'(nreq), 32'(n0));
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_rdy", 32'(HREADYOUT), 32'd1);
    chk("rst_resp", 32'(HRESP), 32'(HRESP_OKAY));
    chk("rst_req", 32'(ahbsram_req), 32'd0);
    chk("rst_addr", 32'(ahbsram_addr), 32'd0);
    chk("rst_size", 32'(ahbsram_size), 32'd0);
    chk("rst_wr", 32'(ahbsram_write), 32'd0);
    HRESETN = 1'b1;
    next_cycle();

    // Unselected NONSEQ must be ignored.
    HSEL = 1'b0; HTRANS = HTRANS_NONSEQ; HADDR = 20'h010; HSIZE = HSIZE_WORD;
    next_cycle(); idle_bus();
    @(negedge HCLK);
    chk("nosel_rdy", 32'(HREADYOUT), 32'd1);
    chk("nosel_req", 32'(ahbsram_req), 32'd0);
    next_cycle();

    xfer("wr_word", 1'b1, HSIZE_WORD, 20'h010, 32'hDEADBEEF, 32'h0);
    xfer("rd_word", 1'b0, HSIZE_WORD, 20'h010, 32'h0, 32'hDEADBEEF);
    xfer("wr_byte", 1'b1, HSIZE_BYTE, 20'h013, 32'hAB000000, 32'h0);
    xfer("rd_lane3", 1'b0, HSIZE_WORD, 20'h010, 32'h0, 32'hABADBEEF);

    // BUSY high for 4 cycles after the address phase.
    addr_phase(1'b1, HSIZE_WORD, 20'h030); BUSY = 1'b1;
    next_cycle(); idle_bus(); HWDATA = 32'h0BADF00D;
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      chk("busy_req", 32'(ahbsram_req), 32'd0);
      chk("busy_rdy", 32'(HREADYOUT), 32'd0);
      next_cycle();
    end
    BUSY = 1'b0;
    @(negedge HCLK); chk("busy_rel_req", 32'(ahbsram_req), 32'd1);
    next_cycle(); @(negedge HCLK); chk("busy_wait_rdy", 32'(HREADYOUT), 32'd0);
    next_cycle(); @(negedge HCLK); chk("busy_ack_rdy", 32'(HREADYOUT), 32'd1);
    next_cycle();
    xfer("rd_busy", 1'b0, HSIZE_WORD, 20'h030, 32'h0, 32'h0BADF00D);

    err_xfer("mis_word", HSIZE_WORD, 20'h002);
    err_xfer("big_size", 3'b011, 20'h010);
    err_xfer("oor_addr", HSIZE_WORD, 20'h800);

    // Back-to-back: read address presented on the write's ack cycle.
    addr_phase(1'b1, HSIZE_WORD, 20'h020);
    next_cycle(); idle_bus(); HWDATA = 32'h12345678;
    @(negedge HCLK); chk("b2b_wr_req", 32'(ahbsram_req), 32'd1);
    next_cycle();
    next_cycle(); addr_phase(1'b0, HSIZE_WORD, 20'h020);
    @(negedge HCLK); chk("b2b_wr_ack_rdy", 32'(HREADYOUT), 32'd1);
    next_cycle(); idle_bus();
    @(negedge HCLK);
    chk("b2b_rd_req", 32'(ahbsram_req), 32'd1);
    chk("b2b_rd_wr", 32'(ahbsram_write), 32'd0);
    next_cycle(); @(negedge HCLK); chk("b2b_rd_wait", 32'(HREADYOUT), 32'd0);
    next_cycle(); @(negedge HCLK);
    chk("b2b_rd_rdy", 32'(HREADYOUT), 32'd1);
    chk("b2b_rd_data", HRDATA, 32'h12345678);
    next_cycle();

    // Reset pulse while waiting for the ack.
    addr_phase(1'b0, HSIZE_WORD, 20'h010);
    next_cycle(); idle_bus();
    next_cycle();
    HRESETN = 1'b0; #1;
    chk("rstmid_rdy", 32'(HREADYOUT), 32'd1);
    chk("rstmid_resp", 32'(HRESP), 32'(HRESP_OKAY));
    chk("rstmid_req", 32'(ahbsram_req), 32'd0);
    @(negedge HCLK); HRESETN = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_cycle(); @(negedge HCLK);
      chk("post_rst_req", 32'(ahbsram_req), 32'd0);
      chk("post_rst_rdy", 32'(HREADYOUT), 32'd1);
    end
    next_cycle();
    xfer("post_rst_rd", 1'b0, HSIZE_WORD, 20'h010, 32'h0, 32'hABADBEEF);

    chk("req_rule_viol", 32'(viol), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
